bsg_link_oddr_deser: RTL
========================

# bsg_link_oddr_deser

Receive-side deserializer for the ODDR link: samples the half-width data bus and forwarded link clock in the core clock domain, locks onto the forwarded-clock toggle pattern, and reassembles each pair of half-words into a full word. Reassembled words are buffered in a small FIFO and presented to the core through a valid/yumi handshake. It is the far-end counterpart of the ODDR transmitter PHY and sits between the link input pads/synchronizers and the core-side link FIFO.

## Interface
- width_p, 16, half-word width carried on the link per core-clock cycle; output word is 2*width_p
- lock_cycles_p, 4, consecutive forwarded-clock toggles required before words are accepted (1..15)
- fifo_els_p, 4, output FIFO depth in words (power of two, >= 2)

- clk_i  in  1  core clock; all logic on rising edge
- reset_n_i  in  1  synchronous, active-low reset
- link_data_i  in  width_p  link data half-word, one per clk_i cycle
- link_clk_i  in  1  forwarded link clock, sampled as data; level 0 marks low half, level 1 marks high half
- data_o  out  2*width_p  head-of-FIFO word, {high half, low half}
- valid_o  out  1  data_o holds a word
- yumi_i  in  1  consumer takes head word this cycle; legal only when valid_o=1
- locked_o  out  1  toggle lock achieved
- overflow_o  out  1  sticky: a completed word was dropped because the FIFO was full

## Operation
- Input stage: d_r <= link_data_i, c_r <= link_clk_i every edge; prev_c_r <= c_r.
- Low-half hold: lo_r <= d_r on any edge where c_r=0.
- Lock counter cnt (saturating at lock_cycles_p):
  - edge with c_r != prev_c_r: cnt <= min(cnt+1, lock_cycles_p)
  - edge with c_r == prev_c_r: cnt <= 0, lock drops (link idle or transmitter in reset)
  - locked_o = (cnt == lock_cycles_p), registered.
- Push condition (using pre-edge values): locked_o=1, c_r=1, prev_c_r=0. Pushed word = {d_r, lo_r}.
- A word is never assembled across a lock loss; a non-toggle discards any pending low half.
- FIFO: push when push condition true and (not full or yumi_i=1). Push while full without yumi_i: word dropped, overflow_o <= 1 (sticky until reset).
- Simultaneous push and pop: both occur, count unchanged; legal when full or when count=1.
- No bypass: a push into an empty FIFO shows valid_o the following cycle.
- yumi_i with valid_o=0 is illegal; design ignores it (no pointer movement).

## Timing
- Reset (reset_n_i=0 at an edge): valid_o=0, locked_o=0, overflow_o=0, cnt=0, FIFO pointers 0, c_r=prev_c_r=0, d_r=lo_r=0. data_o don't-care while valid_o=0.
- Reset mid-operation flushes all FIFO contents and partial words the same edge.
- Lock latency: after reset, with link_clk_i alternating from first cycle, locked_o rises after lock_cycles_p+2 edges (two input-stage edges plus lock_cycles_p toggles).
- Word latency: low half on link pins before edge e0, high half before e1 -> push at e2 -> valid_o=1 after e2 (FIFO previously empty).
- Sustained throughput: one word per two clk_i cycles; FIFO never fills if yumi_i is asserted at least every other cycle.
- Pointers wrap modulo fifo_els_p; full/empty distinguished by an extra pointer bit.

## Test plan
- Lock: reset, drive link_clk_i 0,1,0,1... from cycle 0 with lock_cycles_p=4 -> locked_o=0 through edge 5, 1 after edge 6; no valid_o before lock.
- Reassembly: after lock, send halves 16'h1234 (clk=0) then 16'hABCD (clk=1), yumi_i tied 1 -> data_o=32'hABCD_1234 with valid_o high exactly one cycle, two edges after high half sampled.
- Lock loss: after lock, send low half 16'h5555 with clk=0, then hold clk=0 one extra cycle -> locked_o falls, no word pushed; relock needs 4 new toggles, next word contains only post-relock halves.
- Overflow: fifo_els_p=4, yumi_i=0, stream 5 words 32'h1..32'h5 -> valid_o stays 1, FIFO holds 1..4, overflow_o rises at 5th push; then pop 4 -> data_o sequence 1,2,3,4, valid_o falls.
- Full with simultaneous pop: FIFO full, assert yumi_i on push edge -> no overflow, head advances, new word enters tail.
- Reset mid-stream: two words buffered, overflow_o=1, pulse reset_n_i low one edge -> valid_o=0, locked_o=0, overflow_o=0 next cycle; buffered words never appear.

Source files
------------

// File: rtl/bsg_link_oddr_deser.sv
// bsg_link_oddr_deser: receive-side ODDR link deserializer.
// Samples the half-width link bus and the forwarded clock as data, locks onto
// the forwarded-clock toggle pattern, pairs low/high halves into full words
// and buffers them in a small FIFO behind a valid/yumi handshake.
module bsg_link_oddr_deser #(
   parameter int unsigned width_p       = 16,
   parameter int unsigned lock_cycles_p = 4,
   parameter int unsigned fifo_els_p    = 4
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic [width_p-1:0]     link_data_i,
   input  logic                   link_clk_i,
   output logic [2*width_p-1:0]   data_o,
   output logic                   valid_o,
   input  logic                   yumi_i,
   output logic                   locked_o,
   output logic                   overflow_o
);

   localparam int unsigned word_w = 2 * width_p;
   localparam int unsigned addr_w = $clog2(fifo_els_p);
   localparam int unsigned ptr_w  = addr_w + 1;
   localparam int unsigned cnt_w  = 4;

   logic [width_p-1:0] d_r;
   logic [width_p-1:0] lo_r;
   logic               c_r;
   logic               prev_c_r;
   logic [cnt_w-1:0]   cnt_r;
   logic [ptr_w-1:0]   wptr_r;
   logic [ptr_w-1:0]   rptr_r;
   logic [word_w-1:0]  mem [fifo_els_p];

   logic               toggle;
   logic [cnt_w-1:0]   cnt_n;
   logic               locked_n;
   logic               push_req;
   logic [word_w-1:0]  word;
   logic               full;
   logic               pop;
   logic               push;
   logic               drop;
   logic [ptr_w-1:0]   wptr_n;
   logic [ptr_w-1:0]   rptr_n;
   logic [addr_w-1:0]  rd_idx_n;
   logic [word_w-1:0]  data_n;
   logic               valid_n;

   // Next-state for lock tracking and FIFO bookkeeping.
   always_comb begin
      toggle   = 1'b0;
      cnt_n    = '0;
      locked_n = 1'b0;
      push_req = 1'b0;
      word     = '0;
      full     = 1'b0;
      pop      = 1'b0;
      push     = 1'b0;
      drop     = 1'b0;
      wptr_n   = wptr_r;
      rptr_n   = rptr_r;
      rd_idx_n = '0;
      data_n   = '0;
      valid_n  = 1'b0;

      toggle = (c_r != prev_c_r);
      if (toggle) begin
         cnt_n = (cnt_r == cnt_w'(lock_cycles_p)) ? cnt_r : cnt_r + cnt_w'(1);
      end
      locked_n = (cnt_n == cnt_w'(lock_cycles_p));

      // A rising forwarded clock while locked completes a word whose low
      // half was captured on the previous edge.
      push_req = locked_o & c_r & ~prev_c_r;
      word     = {d_r, lo_r};

      full = (wptr_r[addr_w-1:0] == rptr_r[addr_w-1:0]) &&
             (wptr_r[addr_w] != rptr_r[addr_w]);
      pop  = yumi_i & valid_o;
      push = push_req & (~full | pop);
      drop = push_req & full & ~pop;

      if (push) wptr_n = wptr_r + ptr_w'(1);
      if (pop)  rptr_n = rptr_r + ptr_w'(1);

      // Head word after this edge; a push into an empty FIFO lands on the head.
      rd_idx_n = rptr_n[addr_w-1:0];
      if (push && (wptr_r[addr_w-1:0] == rd_idx_n)) begin
         data_n = word;
      end else begin
         data_n = mem[rd_idx_n];
      end
      valid_n = (wptr_n != rptr_n);
   end

   // Input stage, lock counter, pointers and registered outputs.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         d_r        <= '0;
         lo_r       <= '0;
         c_r        <= 1'b0;
         prev_c_r   <= 1'b0;
         cnt_r      <= '0;
         locked_o   <= 1'b0;
         wptr_r     <= '0;
         rptr_r     <= '0;
         valid_o    <= 1'b0;
         data_o     <= '0;
         overflow_o <= 1'b0;
      end else begin
         d_r      <= link_data_i;
         c_r      <= link_clk_i;
         prev_c_r <= c_r;
         if (!c_r) lo_r <= d_r;
         cnt_r    <= cnt_n;
         locked_o <= locked_n;
         wptr_r   <= wptr_n;
         rptr_r   <= rptr_n;
         valid_o  <= valid_n;
         data_o   <= data_n;
         if (drop) overflow_o <= 1'b1;
      end
   end

   // FIFO storage; contents are meaningless until written, so no reset.
   always_ff @(posedge clk_i) begin
      if (reset_n_i && push) begin
         mem[wptr_r[addr_w-1:0]] <= word;
      end
   end

endmodule
